// File: rtl/alu_pkg.sv
// Shared constants and types for the two-requester ALU arbiter.
package alu_pkg;

   localparam int W    = 16;
   localparam int NREQ = 2;

   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_MUL = 4'b0100;
   localparam logic [3:0] OP_DIV = 4'b0101;
   localparam logic [3:0] OP_CMP = 4'b0110;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational 16-bit unsigned ALU; the arbiter owns every register around it.
module alu_core
   import alu_pkg::*;
(
   input  logic [3:0]   op,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] result,
   output logic         dz,
   output logic         n,
   output logic         z
);

   logic [2*W-1:0] prod;

   assign prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};

   always_comb begin
      result = '0;
      dz     = 1'b0;
      case (op)
         OP_ADD: result = a + b;
         OP_SUB: result = a - b;
         OP_CMP: result = a - b;
         OP_MUL: result = prod[W-1:0];
         OP_DIV: begin
            // Divide by zero saturates to all ones and raises the marker.
            if (b == '0) begin
               result = '1;
               dz     = 1'b1;
            end else begin
               result = a / b;
            end
         end
         default: result = '0;
      endcase
   end

   assign n = result[W-1];
   assign z = (result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin owner of the shared ALU: grant, capture, execute, hold response.
module alu_arbiter #(
   parameter int W    = 16,
   parameter int NREQ = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*4-1:0] req_op,
   input  logic [NREQ*W-1:0] req_a,
   input  logic [NREQ*W-1:0] req_b,
   output logic [NREQ-1:0]   rsp_valid,
   input  logic [NREQ-1:0]   rsp_ready,
   output logic [W-1:0]      rsp_data,
   output logic              rsp_dz,
   output logic              flag_n,
   output logic              flag_z
);

   import alu_pkg::*;

   state_t         state, state_nxt;
   logic           last_grant;
   logic           grant;
   logic           pick;
   logic           accept;
   logic           done;
   logic [3:0]     op_p0;
   logic [W-1:0]   a_p0;
   logic [W-1:0]   b_p0;
   logic [W-1:0]   alu_result;
   logic           alu_dz;
   logic           alu_n;
   logic           alu_z;

   always_comb begin
      state_nxt = state;
      req_ready = '0;
      rsp_valid = '0;
      pick      = 1'b0;
      accept    = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (|req_valid) begin
               // On a tie the requester that was not served last wins.
               pick            = (&req_valid) ? ~last_grant : req_valid[1];
               req_ready[pick] = 1'b1;
               accept          = 1'b1;
               state_nxt       = EXEC;
            end
         end
         EXEC: state_nxt = RESP;
         RESP: begin
            rsp_valid[grant] = 1'b1;
            if (rsp_ready[grant]) begin
               done      = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Stage p0: operand capture on the grant edge
   always_ff @(posedge clk) begin
      if (accept) begin
         op_p0 <= pick ? req_op[7:4]     : req_op[3:0];
         a_p0  <= pick ? req_a[2*W-1:W]  : req_a[W-1:0];
         b_p0  <= pick ? req_b[2*W-1:W]  : req_b[W-1:0];
      end
   end

   alu_core u_alu_core (
      .op     (op_p0),
      .a      (a_p0),
      .b      (b_p0),
      .result (alu_result),
      .dz     (alu_dz),
      .n      (alu_n),
      .z      (alu_z)
   );

   // Stage p1: result, divide marker and compare flags registered at end of EXEC
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         grant      <= 1'b0;
         rsp_data   <= '0;
         rsp_dz     <= 1'b0;
         flag_n     <= 1'b0;
         flag_z     <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            grant <= pick;
         end
         if (state == EXEC) begin
            rsp_data <= alu_result;
            rsp_dz   <= alu_dz;
            if (op_p0 == OP_CMP) begin
               flag_n <= alu_n;
               flag_z <= alu_z;
            end
         end
         if (done) begin
            last_grant <= grant;
         end
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a transaction-level reference model.
module tb_alu_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [7:0]  req_op;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic [1:0]  rsp_valid;
   logic [1:0]  rsp_ready;
   logic [15:0] rsp_data;
   logic        rsp_dz;
   logic        flag_n;
   logic        flag_z;

   int n_cmp = 0;
   int n_bad = 0;

   alu_arbiter #(.W(16), .NREQ(2)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_dz    (rsp_dz),
      .flag_n    (flag_n),
      .flag_z    (flag_z)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference arithmetic straight from the opcode table, in plain integers.
   function automatic logic [16:0] ref_alu(input int op, input longint a, input longint b);
      longint r;
      r = 0;
      case (op)
         1:       r = (a + b) % 65536;
         2, 6:    r = (a - b + 65536) % 65536;
         4:       r = (a * b) % 65536;
         5: begin
            if (b == 0) return {1'b1, 16'hFFFF};
            r = a / b;
         end
         default: r = 0;
      endcase
      return {1'b0, 16'(r)};
   endfunction

   function automatic int pick_req(input logic [1:0] v, input int last);
      if (v == 2'b11) return 1 - last;
      return v[1] ? 1 : 0;
   endfunction

   function automatic int sel_op(input logic [1:0] v, input int last);
      return (pick_req(v, last) == 1) ? int'(req_op[7:4]) : int'(req_op[3:0]);
   endfunction

   function automatic longint sel_a(input logic [1:0] v, input int last);
      return (pick_req(v, last) == 1) ? longint'(req_a[31:16]) : longint'(req_a[15:0]);
   endfunction

   function automatic longint sel_b(input logic [1:0] v, input int last);
      return (pick_req(v, last) == 1) ? longint'(req_b[31:16]) : longint'(req_b[15:0]);
   endfunction

   // Model: m_age = -1 when free, else cycles since the accepting edge.
   int          m_age  = -1;
   int          m_g    = 0;
   int          m_last = 1;
   int          m_op   = 0;
   logic [16:0] m_ra   = '0;
   logic [15:0] m_data = '0;
   logic        m_odz  = 1'b0;
   logic        m_n    = 1'b0;
   logic        m_z    = 1'b0;
   int          dut_grants[$];

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_age  <= -1;
         m_last <= 1;
         m_data <= '0;
         m_odz  <= 1'b0;
         m_n    <= 1'b0;
         m_z    <= 1'b0;
      end else if (m_age < 0) begin
         if (req_valid != 2'b00) begin
            m_g   <= pick_req(req_valid, m_last);
            m_op  <= sel_op(req_valid, m_last);
            m_ra  <= ref_alu(sel_op(req_valid, m_last), sel_a(req_valid, m_last),
                             sel_b(req_valid, m_last));
            m_age <= 1;
         end
      end else if (m_age == 1) begin
         m_data <= m_ra[15:0];
         m_odz  <= m_ra[16];
         if (m_op == 6) begin
            m_n <= m_ra[15];
            m_z <= (m_ra[15:0] == 16'd0);
         end
         m_age <= 2;
      end else if (rsp_ready[m_g]) begin
         m_age  <= -1;
         m_last <= m_g;
      end
   end

   always @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < 2; i++) begin
            if (req_valid[i] && req_ready[i]) dut_grants.push_back(i);
         end
      end
   end

   always @(negedge clk) begin
      logic [1:0] exp_ready;
      logic [1:0] exp_rv;
      exp_ready = 2'b00;
      exp_rv    = 2'b00;
      if (m_age < 0 && req_valid != 2'b00) exp_ready = 2'b01 << pick_req(req_valid, m_last);
      if (m_age >= 2) exp_rv = 2'b01 << m_g;
      chk("req_ready", {30'd0, req_ready}, {30'd0, exp_ready});
      chk("rsp_valid", {30'd0, rsp_valid}, {30'd0, exp_rv});
      chk("rsp_data", {16'd0, rsp_data}, {16'd0, m_data});
      chk("rsp_dz", {31'd0, rsp_dz}, {31'd0, m_odz});
      chk("flag_n", {31'd0, flag_n}, {31'd0, m_n});
      chk("flag_z", {31'd0, flag_z}, {31'd0, m_z});
   end

   task automatic do_op(input int r, input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] ed, input logic edz,
                        input logic en, input logic ez);
      bit ok;
      int lat;
      @(posedge clk);
      #1;
      req_op[r*4 +: 4]  = op;
      req_a[r*16 +: 16] = a;
      req_b[r*16 +: 16] = b;
      req_valid[r]      = 1'b1;
      ok = 1'b0;
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         if (req_ready[r]) begin
            ok = 1'b1;
            break;
         end
      end
      chk("accept", {31'd0, ok}, 32'd1);
      @(posedge clk);
      #1;
      req_valid[r] = 1'b0;
      ok  = 1'b0;
      lat = 0;
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         lat++;
         if (rsp_valid[r]) begin
            ok = 1'b1;
            break;
         end
      end
      chk("rsp_seen", {31'd0, ok}, 32'd1);
      chk("latency", lat, 32'd2);
      chk("lit_data", {16'd0, rsp_data}, {16'd0, ed});
      chk("lit_dz", {31'd0, rsp_dz}, {31'd0, edz});
      chk("lit_n", {31'd0, flag_n}, {31'd0, en});
      chk("lit_z", {31'd0, flag_z}, {31'd0, ez});
      #1;
      rsp_ready[r] = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready[r] = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      reset     = 1'b1;
      req_valid = 2'b00;
      rsp_ready = 2'b00;
      req_op    = '0;
      req_a     = '0;
      req_b     = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
      chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
      chk("rst_rsp_data", {16'd0, rsp_data}, 32'd0);
      chk("rst_flags", {30'd0, flag_n, flag_z}, 32'd0);

      do_op(0, 4'b0001, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b0);
      do_op(1, 4'b0110, 16'd5,    16'd5,    16'h0000, 1'b0, 1'b0, 1'b1);
      do_op(1, 4'b0110, 16'd3,    16'd5,    16'hFFFE, 1'b0, 1'b1, 1'b0);
      do_op(0, 4'b0001, 16'd2,    16'd3,    16'h0005, 1'b0, 1'b1, 1'b0);
      do_op(0, 4'b0101, 16'd100,  16'd0,    16'hFFFF, 1'b1, 1'b1, 1'b0);
      do_op(1, 4'b0101, 16'd100,  16'd7,    16'd14,   1'b0, 1'b1, 1'b0);
      do_op(0, 4'b0100, 16'h0100, 16'h0101, 16'h0100, 1'b0, 1'b1, 1'b0);
      do_op(1, 4'b0011, 16'h1234, 16'h0001, 16'h0000, 1'b0, 1'b1, 1'b0);

      // Back-pressure on requester 0 while requester 1 briefly asks and withdraws.
      @(posedge clk);
      #1;
      req_op[3:0] = 4'b0001;
      req_a[15:0] = 16'd10;
      req_b[15:0] = 16'd20;
      req_valid   = 2'b01;
      @(posedge clk);
      #1;
      req_valid = 2'b00;
      ok = 1'b0;
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         if (rsp_valid[0]) begin
            ok = 1'b1;
            break;
         end
      end
      chk("bp_rsp_seen", {31'd0, ok}, 32'd1);
      #1;
      req_op[7:4] = 4'b0001;
      req_valid   = 2'b10;
      for (int t = 0; t < 5; t++) begin
         @(negedge clk);
         chk("bp_req_ready", {30'd0, req_ready}, 32'd0);
         chk("bp_rsp_valid", {30'd0, rsp_valid}, 32'd1);
         chk("bp_rsp_data", {16'd0, rsp_data}, 32'd30);
         if (t == 2) begin
            #1;
            req_valid = 2'b00;
         end
      end
      #1;
      rsp_ready[0] = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 2'b11;
      for (int t = 0; t < 3; t++) begin
         @(negedge clk);
         chk("idle_rsp_valid", {30'd0, rsp_valid}, 32'd0);
         chk("idle_req_ready", {30'd0, req_ready}, 32'd0);
      end
      #1;
      rsp_ready = 2'b00;

      // Reset while requester 1 holds a pending CMP result.
      @(posedge clk);
      #1;
      req_op[7:4]   = 4'b0110;
      req_a[31:16]  = 16'd3;
      req_b[31:16]  = 16'd5;
      req_valid     = 2'b10;
      @(posedge clk);
      #1;
      req_valid = 2'b00;
      @(negedge clk);
      @(negedge clk);
      chk("pre_rst_rsp_valid", {30'd0, rsp_valid}, 32'd2);
      chk("pre_rst_flag_n", {31'd0, flag_n}, 32'd1);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("mid_rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
      chk("mid_rst_rsp_data", {16'd0, rsp_data}, 32'd0);
      chk("mid_rst_dz", {31'd0, rsp_dz}, 32'd0);
      chk("mid_rst_flags", {30'd0, flag_n, flag_z}, 32'd0);
      reset = 1'b0;
      dut_grants.delete();

      // Continuous contention: grants must alternate starting with requester 0.
      @(posedge clk);
      #1;
      req_op    = {4'b0010, 4'b0001};
      req_a     = {16'd10, 16'd1};
      req_b     = {16'd4,  16'd2};
      rsp_ready = 2'b11;
      req_valid = 2'b11;
      repeat (12) @(posedge clk);
      #1;
      req_valid = 2'b00;
      repeat (4) @(posedge clk);
      #1;
      rsp_ready = 2'b00;
      chk("grant_count", {31'd0, dut_grants.size() >= 4}, 32'd1);
      for (int i = 0; i < 4; i++) begin
         chk("grant_order", (i < dut_grants.size()) ? dut_grants[i] : -1, i % 2);
      end
      @(negedge clk);
      chk("final_rsp_valid", {30'd0, rsp_valid}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
